// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - host handshake and operand/result bundle for serial_sub_ctrl
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b - bin using one full_sub cell per clock, LSB first
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_sub_ctrl_if.slave     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             brw;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] res_next;

    full_sub u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    assign res_next = {cell_d, res_sh[WIDTH-1:1]};
    assign accept   = ((state == IDLE) || (state == DONE)) && bus.start;
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            res_sh <= '0;
            state  <= RUN;
        end else begin
            case (state)
                RUN: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    brw    <= cell_bo;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        diff_q <= res_next;
                        bout_q <= cell_bo;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It computes a - b - bin for WIDTH-bit operands by sequencing one instance of the existing full_sub cell once per clock, LSB first. The borrow is carried between cycles in a flip-flop. A start/busy/done handshake lets a host issue subtractions using one 1-bit cell instead of a WIDTH-bit ripple chain.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk      input   1      system clock; all state updates on rising edge
rst_n    input   1      reset; one clock; reset is synchronous and active-low
start    input   1      request a subtraction; sampled only when not busy
a        input   WIDTH  minuend; captured on the accepting edge
b        input   WIDTH  subtrahend; captured on the accepting edge
bin      input   1      initial borrow-in; captured on the accepting edge
busy     output  1      high while the operation is in progress
done     output  1      one-cycle pulse when diff/bout become valid
diff     output  WIDTH  result (a - b - bin) mod 2**WIDTH
bout     output  1      final borrow-out; 1 when a < b + bin, unsigned

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, busy=0, done=0, diff=0, bout=0.
  - Shift registers, borrow flop and counter are cleared.
  - Reset takes priority over every other event, including mid-RUN; a partial result is discarded and never reported.
- States:
  - IDLE: busy=0. On an edge with start=1:
    - a_sh<=a, b_sh<=b, brw<=bin, cnt<=0, res_sh<=0.
    - Go to RUN.
  - RUN: busy=1. Each edge:
    - Cell inputs are a_sh[0], b_sh[0], brw.
    - res_sh <= {cell.diff, res_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right one bit.
    - brw <= cell.bout.
    - cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: diff<=final shifted res_sh, bout<=cell.bout, done<=1, go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle.
    - Next edge with start=1: accept new operands as in IDLE and go to RUN, so back-to-back operation has no idle gap.
    - Next edge with start=0: go to IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the edge that accepted start. Throughput is one result per WIDTH+1 cycles when start is held high.
- diff and bout are registered outputs. They change only at completion (or reset) and hold their value through IDLE and the following RUN.
- start while busy=1 is ignored. Operands are not re-sampled, and a, b, bin may change freely during RUN.
- The cell is purely combinational. Controller outputs have no combinational path from any input.
- Arithmetic matches WIDTH chained full_sub cells: diff = (a - b - bin) mod 2**WIDTH, and bout is the borrow out of bit WIDTH-1.
- Edge cases:
  - bin=1 with a==b gives diff=all ones, bout=1.
  - a=0, b=0, bin=0 gives diff=0, bout=0.

Test Plan:
- Basic, WIDTH=8: reset 2 cycles; a=0x05, b=0x03, bin=0, start pulse.
  - Required: busy high for 8 cycles, then done pulse.
  - Required: diff=0x02, bout=0, busy=0.
- Underflow: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. With bin=1, a=0x00, b=0x00 -> diff=0xFF, bout=1.
- Exhaustive small width, WIDTH=2: all 32 (a, b, bin) combinations. Each must match {bout,diff} = a - b - bin in 3-bit two's complement. Check done is exactly one cycle wide.
- Ignore start while busy: start a=0xFF, b=0x01. Pulse start with a=0x00, b=0x80 at cycle 3.
  - Required: result diff=0xFE, bout=0.
  - Required: done occurs once, at the original time.
- Back-to-back: hold start=1 with a=0x10, b=0x01, then a=0x20, b=0x30.
  - Required: done pulses 9 cycles apart.
  - Required results: 0x0F/bout 0, then 0xF0/bout 1.
  - Required: diff holds 0x0F between the two done pulses.
- Reset mid-operation: assert rst_n=0 for one edge at RUN cycle 4.
  - Required: busy=0, done=0, diff=0, bout=0, and no done pulse follows.
  - A new start afterwards gives a correct result.
